instr_prefetch_queue: RTL and testbench

//  Instruction-fetch front end feeding the IF_ID register of the Datapath1 pipeline.

---
 rtl/instr_prefetch_queue.sv | 137 +++++++++++++
 tb/tb_instr_prefetch_queue.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: issues sequential reads to instruction memory over a
// req/ack handshake, buffers the returned words in a small FIFO and presents the head
// word with its address to the IF/ID stage. A redirect flushes the queue and restarts
// fetch at the branch target; a request already in flight is completed and discarded.
module instr_prefetch_queue #(
  parameter int unsigned PC_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     redirect,
  input  logic [PC_WIDTH-1:0]      redirectPc,
  input  logic                     stall,
  output logic                     memReq,
  output logic [PC_WIDTH-1:0]      memAddr,
  input  logic                     memAck,
  input  logic [DATA_WIDTH-1:0]    memData,
  output logic                     valid,
  output logic [DATA_WIDTH-1:0]    instruction,
  output logic [PC_WIDTH-1:0]      pcOut,
  output logic [PC_WIDTH-1:0]      pcNext,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PC_WIDTH-1:0]   pc_mem   [DEPTH];

  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                req_q, req_d;
  logic [PC_WIDTH-1:0] addr_q, addr_d;
  logic                drop_q, drop_d;

  logic xfer;
  logic push;
  logic pop;
  logic head_valid;

  assign head_valid = (count_q != '0);
  assign xfer       = req_q & memAck;
  // A redirect discards both the returning word and the consumed head.
  assign push       = xfer & ~drop_q & ~redirect;
  assign pop        = head_valid & ~stall & ~redirect;

  // Next-state: flush/redirect, FIFO bookkeeping and request issue.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    req_d      = req_q;
    addr_d     = addr_q;

    if (redirect) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirectPc;
      // A request still waiting for its ack must complete, and its data is thrown away.
      drop_d     = req_q & ~memAck;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PtrW'(1);
        fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
      if (xfer && drop_q) begin
        drop_d = 1'b0;
      end
    end

    if (req_q && !memAck) begin
      // Request and address are held until the ack edge.
      req_d  = 1'b1;
      addr_d = addr_q;
    end else begin
      // No new request on a redirect edge or on the edge retiring a dropped ack.
      req_d  = (count_d < CntW'(DEPTH)) & ~drop_q & ~redirect;
      addr_d = fetch_pc_d;
    end
  end

  // Control state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      drop_q     <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      drop_q     <= drop_d;
    end
  end

  // FIFO storage; contents are only observed through the count-qualified head.
  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr_q] <= memData;
      pc_mem[wr_ptr_q]   <= addr_q;
    end
  end

  // Head presentation: NOP and zero address while empty.
  always_comb begin
    valid       = head_valid;
    instruction = '0;
    pcOut       = '0;
    if (head_valid) begin
      instruction = data_mem[rd_ptr_q];
      pcOut       = pc_mem[rd_ptr_q];
    end
    pcNext  = pcOut + PC_WIDTH'(1);
    count   = count_q;
    memReq  = req_q;
    memAddr = addr_q;
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: directed scenarios plus a randomized run against a
// stream-level reference (after reset or a redirect the consumed words must be the
// consecutive addresses from the restart point, each carrying that address's word).
module tb_instr_prefetch_queue;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [7:0]  redirectPc = 8'h00;
  logic        stall = 1'b0;
  logic        memReq;
  logic [7:0]  memAddr;
  logic        memAck = 1'b0;
  logic [31:0] memData = 32'h0;
  logic        valid;
  logic [31:0] instruction;
  logic [7:0]  pcOut;
  logic [7:0]  pcNext;
  logic [2:0]  count;

  instr_prefetch_queue #(
    .PC_WIDTH  (8),
    .DATA_WIDTH(32),
    .DEPTH     (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .stall      (stall),
    .memReq     (memReq),
    .memAddr    (memAddr),
    .memAck     (memAck),
    .memData    (memData),
    .valid      (valid),
    .instruction(instruction),
    .pcOut      (pcOut),
    .pcNext     (pcNext),
    .count      (count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] ins;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] next_pc = 8'h00;
  int         wait_left = 0;
  int         max_wait = 0;
  bit         fixed_wait = 1'b0;
  bit         junk_ack = 1'b0;
  bit         mon_en = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return 32'h1000_0000 + {24'h0, a};
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: memory model responds, scoreboard restarts on a redirect that just took effect.
  task automatic cycle();
    logic       xfer;
    logic       was_redir;
    logic [7:0] tgt;
    @(negedge clock);
    xfer      = memReq && memAck;
    was_redir = redirect;
    tgt       = redirectPc;
    @(posedge clock);
    #1;
    if (was_redir) begin
      exp_q.delete();
      next_pc = tgt;
    end
    if (xfer) wait_left = fixed_wait ? max_wait : $urandom_range(max_wait, 0);
    if (memReq) begin
      if (wait_left == 0) begin
        memAck  = 1'b1;
        memData = mem_word(memAddr);
      end else begin
        memAck  = 1'b0;
        memData = $urandom;
        wait_left--;
      end
    end else begin
      memAck  = junk_ack && ($urandom_range(3, 0) == 0);
      memData = $urandom;
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back({next_pc, mem_word(next_pc)});
      next_pc++;
    end
  endtask

  task automatic do_reset();
    redirect = 1'b0;
    stall    = 1'b0;
    mon_en   = 1'b0;
    reset    = 1'b0;
    #1;
    chk("rst_valid", {39'h0, valid}, 40'h0);
    chk("rst_instr", {8'h0, instruction}, 40'h0);
    chk("rst_pcout", {32'h0, pcOut}, 40'h0);
    chk("rst_pcnext", {32'h0, pcNext}, 40'h1);
    chk("rst_count", {37'h0, count}, 40'h0);
    chk("rst_memreq", {39'h0, memReq}, 40'h0);
    chk("rst_memaddr", {32'h0, memAddr}, 40'h0);
    repeat (2) cycle();
    exp_q.delete();
    next_pc   = 8'h00;
    wait_left = fixed_wait ? max_wait : 0;
    reset     = 1'b1;
    mon_en    = 1'b1;
  endtask

  // Monitor: invariants every cycle and head-vs-scoreboard whenever valid.
  logic       hold = 1'b0;
  logic [7:0] hold_addr = 8'h00;
  always @(negedge clock) begin
    if (!mon_en || !reset) begin
      hold = 1'b0;
    end else begin
      if (!valid) chk("nop_when_empty", {8'h0, instruction}, 40'h0);
      chk("pcnext_rel", {32'h0, pcNext}, {32'h0, 8'(pcOut + 8'd1)});
      chk("valid_vs_count", {39'h0, valid}, {39'h0, (count != 3'd0)});
      chk("count_bound", {39'h0, (count <= 3'(DEPTH))}, 40'h1);
      if (count == 3'(DEPTH)) chk("no_req_when_full", {39'h0, memReq}, 40'h0);
      if (hold) begin
        chk("req_held", {39'h0, memReq}, 40'h1);
        chk("addr_held", {32'h0, memAddr}, {32'h0, hold_addr});
      end
      hold      = memReq && !memAck;
      hold_addr = memAddr;
      if (valid) begin
        if (exp_q.size() == 0) begin
          chk("head_unexpected", {39'h0, valid}, 40'h0);
        end else begin
          chk("head", {pcOut, instruction}, {exp_q[0].pc, exp_q[0].ins});
          if (!stall) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bit found;

    // Zero-wait streaming from reset.
    max_wait = 0; fixed_wait = 1'b1; junk_ack = 1'b0;
    do_reset();
    cycle();
    chk("t1_e1_valid", {39'h0, valid}, 40'h0);
    chk("t1_e1_req", {39'h0, memReq}, 40'h1);
    chk("t1_e1_addr", {32'h0, memAddr}, 40'h0);
    cycle();
    chk("t1_e2_valid", {39'h0, valid}, 40'h1);
    chk("t1_e2_pc", {32'h0, pcOut}, 40'h0);
    chk("t1_e2_instr", {8'h0, instruction}, {8'h0, mem_word(8'h00)});
    cycle();
    chk("t1_e3_pc", {32'h0, pcOut}, 40'h1);
    chk("t1_e3_pcnext", {32'h0, pcNext}, 40'h2);

    // Stall long enough to fill the queue.
    repeat (3) cycle();
    stall = 1'b1;
    repeat (6) cycle();
    chk("t2_count_full", {37'h0, count}, 40'h4);
    chk("t2_req_off", {39'h0, memReq}, 40'h0);
    chk("t2_valid", {39'h0, valid}, 40'h1);
    stall = 1'b0;
    repeat (10) cycle();

    // Three-cycle memory latency.
    max_wait = 3;
    do_reset();
    cycle();
    chk("t3_req", {39'h0, memReq}, 40'h1);
    repeat (3) begin
      cycle();
      chk("t3_empty_valid", {39'h0, valid}, 40'h0);
      chk("t3_empty_instr", {8'h0, instruction}, 40'h0);
      chk("t3_addr_stable", {32'h0, memAddr}, 40'h0);
    end
    cycle();
    chk("t3_first_valid", {39'h0, valid}, 40'h1);
    chk("t3_first_pc", {32'h0, pcOut}, 40'h0);

    // Redirect while the request to 0x05 is waiting for its ack.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle();
      if (memReq && memAddr == 8'h05 && !memAck) found = 1'b1;
    end
    chk("t4_found_req05", {39'h0, found}, 40'h1);
    redirect = 1'b1; redirectPc = 8'h40;
    cycle();
    redirect = 1'b0;
    chk("t4_req_kept", {39'h0, memReq}, 40'h1);
    chk("t4_addr_kept", {32'h0, memAddr}, 40'h5);
    chk("t4_flushed", {37'h0, count}, 40'h0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (valid) found = 1'b1;
    end
    chk("t4_valid_seen", {39'h0, found}, 40'h1);
    chk("t4_pc", {32'h0, pcOut}, 40'h40);
    chk("t4_pcnext", {32'h0, pcNext}, 40'h41);

    // Wrap of the fetch pointer.
    max_wait = 0;
    redirect = 1'b1; redirectPc = 8'hFE;
    cycle();
    redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (valid && pcOut == 8'hFF) found = 1'b1;
    end
    chk("t5_ff_seen", {39'h0, found}, 40'h1);
    chk("t5_pcnext_wrap", {32'h0, pcNext}, 40'h0);
    repeat (4) cycle();

    // Reset with three entries queued.
    do_reset();
    stall = 1'b1;
    repeat (4) cycle();
    chk("t6_count3", {37'h0, count}, 40'h3);
    do_reset();
    repeat (2) cycle();
    chk("t6_restart_valid", {39'h0, valid}, 40'h1);
    chk("t6_restart_pc", {32'h0, pcOut}, 40'h0);

    // Randomized traffic.
    fixed_wait = 1'b0; max_wait = 3; junk_ack = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if ($urandom_range(999, 0) == 0) begin
        do_reset();
      end else begin
        stall      = ($urandom_range(99, 0) < 30);
        redirect   = ($urandom_range(99, 0) < 4);
        redirectPc = 8'($urandom);
      end
    end
    redirect = 1'b0;
    stall    = 1'b0;
    repeat (5) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
